// File: rtl/lvds_word_align.sv
// Purpose: find the K28.5 comma in a bit-rotated 10-bit deserializer stream, lock to its offset, emit realigned words.
// Latency: one cycle from a valid input word to the aligned output word.
// Backpressure: none; din_vld gates every state update, and dout_vld is low on cycles after an invalid input.
module lvds_word_align #(
  parameter logic [9:0] COMMA_P  = 10'b0011111010,
  parameter logic [9:0] COMMA_N  = 10'b1100000101,
  parameter int         LOCK_CNT = 4,
  parameter int         MIS_MAX  = 3,
  parameter int         TIMEOUT  = 1023
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [9:0]  din,
  input  logic        din_vld,
  output logic [9:0]  dout,
  output logic        dout_vld,
  output logic        locked,
  output logic [3:0]  offset,
  output logic [15:0] err_cnt
);

  typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} state_t;

  state_t      state_q;
  logic [9:0]  prev_q;
  logic [9:0]  dout_q;
  logic        dout_vld_q;
  logic        locked_q;
  logic [3:0]  offset_q;
  logic [15:0] err_q;
  logic [3:0]  hits_q;
  logic [3:0]  mis_q;
  logic [15:0] tmo_q;

  // The top bit of the 20-bit window is never part of any candidate, so it is not built.
  logic [18:0] win;
  logic [9:0]  cand [10];
  logic [9:0]  match;
  logic [3:0]  first_k;
  logic        any_match;
  logic        at_off;
  logic [9:0]  cand_off;
  logic [3:0]  hits_inc;
  logic [3:0]  mis_inc;
  logic [16:0] tmo_inc;
  logic        tmo_hit;
  logic        lock_drop;

  // Comma search across all ten bit offsets of the previous+current word window.
  always_comb begin
    win = {din[8:0], prev_q};
    match = '0;
    first_k = 4'd0;
    for (int k = 0; k < 10; k++) begin
      cand[k] = win[k +: 10];
      match[k] = (cand[k] == COMMA_P) || (cand[k] == COMMA_N);
    end
    for (int k = 9; k >= 0; k--) begin
      if (match[k]) first_k = 4'(k);
    end
    any_match = |match;
    at_off    = match[offset_q];
    cand_off  = cand[offset_q];
    hits_inc  = hits_q + 4'd1;
    mis_inc   = mis_q + 4'd1;
    tmo_inc   = {1'b0, tmo_q} + 17'd1;
    tmo_hit   = (tmo_inc == 17'(TIMEOUT));
    // A comma at the locked offset always wins over foreign matches in the same window.
    lock_drop = !at_off && ((any_match && (mis_inc == 4'(MIS_MAX))) || tmo_hit);
  end

  // Alignment FSM with registered data path and status outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= SEARCH;
      prev_q     <= '0;
      dout_q     <= '0;
      dout_vld_q <= 1'b0;
      locked_q   <= 1'b0;
      offset_q   <= '0;
      err_q      <= '0;
      hits_q     <= '0;
      mis_q      <= '0;
      tmo_q      <= '0;
    end else if (!din_vld) begin
      dout_vld_q <= 1'b0;
    end else begin
      prev_q     <= din;
      dout_q     <= cand_off;
      dout_vld_q <= (state_q == LOCKED);
      case (state_q)
        SEARCH: begin
          if (any_match) begin
            offset_q <= first_k;
            hits_q   <= 4'd1;
            tmo_q    <= '0;
            state_q  <= VERIFY;
          end
        end
        VERIFY: begin
          if (at_off) begin
            hits_q <= hits_inc;
            tmo_q  <= '0;
            if (hits_inc == 4'(LOCK_CNT)) begin
              state_q  <= LOCKED;
              locked_q <= 1'b1;
              mis_q    <= '0;
            end
          end else if (any_match) begin
            offset_q <= first_k;
            hits_q   <= 4'd1;
            tmo_q    <= '0;
          end else if (tmo_hit) begin
            state_q <= SEARCH;
            tmo_q   <= '0;
          end else begin
            tmo_q <= tmo_inc[15:0];
          end
        end
        LOCKED: begin
          if (at_off) begin
            tmo_q <= '0;
            mis_q <= '0;
          end else if (lock_drop) begin
            // Offset keeps its last value so the debug view shows where lock was lost.
            state_q  <= SEARCH;
            locked_q <= 1'b0;
            tmo_q    <= '0;
            mis_q    <= '0;
            if (err_q != 16'hFFFF) err_q <= err_q + 16'd1;
          end else begin
            tmo_q <= tmo_inc[15:0];
            if (any_match) mis_q <= mis_inc;
          end
        end
        default: state_q <= SEARCH;
      endcase
    end
  end

  assign dout     = dout_q;
  assign dout_vld = dout_vld_q;
  assign locked   = locked_q;
  assign offset   = offset_q;
  assign err_cnt  = err_q;

endmodule

// File: tb/tb_lvds_word_align.sv
// Bench for lvds_word_align: randomized comma streams at chosen bit rotations,
// compared every cycle against a word-level reference model, plus directed
// lock-timing, relock, timeout and reset checks.
module tb_lvds_word_align;

  localparam int         TMO = 16;
  localparam logic [9:0] KP  = 10'b0011111010;
  localparam logic [9:0] KN  = 10'b1100000101;
  localparam int HUNT = 0, CONFIRM = 1, TRACK = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [9:0]  din = '0;
  logic        din_vld = 1'b0;
  logic [9:0]  dout;
  logic        dout_vld;
  logic        locked;
  logic [3:0]  offset;
  logic [15:0] err_cnt;

  always #5 clk = ~clk;

  lvds_word_align #(.TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .din_vld(din_vld),
    .dout(dout), .dout_vld(dout_vld), .locked(locked),
    .offset(offset), .err_cnt(err_cnt)
  );

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: word-level view of the receiver.
  int         md = HUNT, moff = 0, mhits = 0, mmis = 0, mtmo = 0, merr = 0;
  logic [9:0] mprev = '0;
  logic [9:0] edout = '0;
  bit         evld = 1'b0;

  function automatic bit is_k(input logic [9:0] v);
    return (v == KP) || (v == KN);
  endfunction

  task automatic model_edge(input logic [9:0] d, input bit v, input bit r);
    logic [19:0] wv;
    int          first;
    bit          here;
    if (!r) begin
      md = HUNT; mprev = '0; moff = 0; mhits = 0; mmis = 0; mtmo = 0;
      merr = 0; edout = '0; evld = 1'b0;
      return;
    end
    if (!v) begin
      evld = 1'b0;
      return;
    end
    wv = {d, mprev};
    first = -1;
    for (int k = 9; k >= 0; k--)
      if (is_k(10'(wv >> k))) first = k;
    here  = is_k(10'(wv >> moff));
    edout = 10'(wv >> moff);
    evld  = (md == TRACK);
    case (md)
      HUNT: if (first >= 0) begin
        moff = first; mhits = 1; mtmo = 0; md = CONFIRM;
      end
      CONFIRM: begin
        if (here) begin
          mhits++; mtmo = 0;
          if (mhits == 4) begin md = TRACK; mmis = 0; end
        end else if (first >= 0) begin
          moff = first; mhits = 1; mtmo = 0;
        end else begin
          mtmo++;
          if (mtmo == TMO) md = HUNT;
        end
      end
      default: begin
        if (here) begin
          mtmo = 0; mmis = 0;
        end else begin
          mtmo++;
          if (first >= 0) mmis++;
          if (mmis == 3 || mtmo == TMO) begin
            md = HUNT;
            if (merr < 65535) merr++;
          end
        end
      end
    endcase
    mprev = d;
  endtask

  task automatic step(input logic [9:0] d, input bit v, input bit r);
    din = d; din_vld = v; rst_n = r;
    @(posedge clk);
    model_edge(d, v, r);
    #1;
    check("dout",     32'(dout),     32'(edout));
    check("dout_vld", 32'(dout_vld), 32'(evld));
    check("locked",   32'(locked),   32'(md == TRACK));
    check("offset",   32'(offset),   32'(moff));
    check("err_cnt",  32'(err_cnt),  32'(merr));
  endtask

  // Data words built from 01/10 bit pairs never hold a run of more than two,
  // so no comma can appear anywhere except where one was sent.
  function automatic logic [9:0] data_word();
    logic [9:0] w;
    w = '0;
    for (int i = 0; i < 5; i++)
      w[2*i +: 2] = ($urandom_range(0, 1) == 1) ? 2'b01 : 2'b10;
    return w;
  endfunction

  int         per;
  logic [9:0] old_src = '0;

  // vmode: 0 always valid, 1 toggling, 2 random. d is the bit rotation, which is the expected offset.
  task automatic run_phase(input int n, input int d, input bit commas, input int vmode,
                           input bit noise, output int first_lock, output int first_unlock);
    int          j;
    bit          v, tog;
    logic [9:0]  src;
    logic [19:0] cat;
    j = 0; tog = 1'b1; first_lock = -1; first_unlock = -1;
    while (j < n) begin
      v = (vmode == 0) ? 1'b1 : (vmode == 1) ? tog : 1'($urandom_range(0, 1));
      tog = ~tog;
      if (v) begin
        if (noise) begin
          src = 10'($urandom);
          step(src, 1'b1, 1'b1);
        end else begin
          if (commas && (j % per == 0)) src = ($urandom_range(0, 1) == 1) ? KP : KN;
          else src = data_word();
          cat = {src, old_src};
          old_src = src;
          step(10'(cat >> (10 - d)), 1'b1, 1'b1);
        end
        if (locked && first_lock < 0) first_lock = j;
        if (!locked && first_unlock < 0) first_unlock = j;
        j++;
      end else begin
        step(10'($urandom), 1'b0, 1'b1);
      end
    end
  endtask

  task automatic expect_lock(input string tag, input int d, input int err);
    check({tag, "_locked"}, 32'(locked), 32'd1);
    check({tag, "_offset"}, 32'(offset), 32'(d));
    check({tag, "_err"},    32'(err_cnt), 32'(err));
  endtask

  initial begin
    int fl, fu, n;
    per = $urandom_range(5, 10);
    n = 12 * per + 1;

    for (int i = 0; i < 3; i++) step(10'($urandom), 1'b1, 1'b0);
    check("rst_locked",   32'(locked),   32'd0);
    check("rst_dout_vld", 32'(dout_vld), 32'd0);
    check("rst_offset",   32'(offset),   32'd0);
    check("rst_err",      32'(err_cnt),  32'd0);
    check("rst_dout",     32'(dout),     32'd0);

    // Aligned stream: lock one word after the fourth comma reaches the window.
    run_phase(n, 0, 1'b1, 0, 1'b0, fl, fu);
    check("lock_time", 32'(fl), 32'(3 * per + 1));
    expect_lock("aligned", 0, 0);

    // Rotation change: foreign commas drop lock, then relock at the new offset.
    run_phase(n, 3, 1'b1, 0, 1'b0, fl, fu);
    expect_lock("rot3", 3, 1);
    run_phase(n, 7, 1'b1, 0, 1'b0, fl, fu);
    expect_lock("rot7", 7, 2);

    // Comma-free data: lock drops on the sixteenth valid word without a comma.
    run_phase(20, 7, 1'b0, 0, 1'b0, fl, fu);
    check("tmo_drop_idx", 32'(fu), 32'd16);
    check("tmo_locked",   32'(locked),  32'd0);
    check("tmo_err",      32'(err_cnt), 32'd3);
    check("tmo_offset",   32'(offset),  32'd7);
    run_phase(n, 7, 1'b1, 0, 1'b0, fl, fu);
    expect_lock("tmo_relock", 7, 3);

    // Toggling qualifier with a new rotation.
    run_phase(n, 5, 1'b1, 1, 1'b0, fl, fu);
    expect_lock("toggle", 5, 4);

    // Single-cycle reset while locked.
    step(10'($urandom), 1'b1, 1'b0);
    check("mid_rst_locked",   32'(locked),   32'd0);
    check("mid_rst_dout_vld", 32'(dout_vld), 32'd0);
    check("mid_rst_offset",   32'(offset),   32'd0);
    check("mid_rst_err",      32'(err_cnt),  32'd0);
    run_phase(n, 0, 1'b1, 0, 1'b0, fl, fu);
    check("relock_time", 32'(fl), 32'(3 * per + 1));
    expect_lock("relock", 0, 0);

    // Unstructured random words with random qualifier, model-checked only.
    run_phase(150, 0, 1'b0, 2, 1'b1, fl, fu);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
